// File: rtl/avl_cmd_master.sv
// avl_cmd_master: executes single read/write commands as avl bus transfers.
// Command handshake: a command transfers on a rising clock edge where
// cmd_valid and cmd_ready are both 1. The initiator holds cmd_* stable while
// cmd_valid is high and not yet taken. rsp_valid is a one-cycle strobe with
// no backpressure; the rsp_* fields stay valid until the next response.
module avl_cmd_master #(
    parameter int pADDR_WIDTH = 8,
    parameter int pDATA_WIDTH = 32,
    parameter int pRD_LATENCY = 1,
    parameter int pTIMEOUT    = 255
) (
    input  logic                   avl_clock,
    input  logic                   avl_rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wrdata,
    output logic                   rsp_valid,
    output logic                   rsp_write,
    output logic [pDATA_WIDTH-1:0] rsp_rddata,
    output logic                   rsp_timeout,
    output logic                   irq_pulse,
    output logic [pADDR_WIDTH-1:0] m_avl_addr,
    output logic                   m_avl_wrena,
    output logic [pDATA_WIDTH-1:0] m_avl_wrdata,
    output logic                   m_avl_rdena,
    input  logic [pDATA_WIDTH-1:0] m_avl_rddata,
    input  logic                   m_avl_irq,
    input  logic                   m_avl_wrq
);

    // A zero timeout still needs a one-bit counter so the vector is legal.
    localparam int WCW = (pTIMEOUT > 0) ? $clog2(pTIMEOUT + 1) : 1;
    // wait_cnt value seen in the pTIMEOUT-th stalled strobe cycle.
    localparam logic [WCW-1:0] WAIT_LAST = (pTIMEOUT > 0) ? WCW'(pTIMEOUT - 1) : '0;
    // lat_cnt reload so that capture happens pRD_LATENCY cycles after acceptance.
    localparam logic [3:0] LAT_LOAD = (pRD_LATENCY > 0) ? 4'(pRD_LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic                   write_q;
    logic [pADDR_WIDTH-1:0] addr_q;
    logic [pDATA_WIDTH-1:0] wrdata_q;
    logic [WCW-1:0]         wait_cnt;
    logic [3:0]             lat_cnt;
    logic                   irq_q;

    logic cmd_take;
    logic bus_accept;
    logic time_out;
    logic rd_capture;

    assign m_avl_addr   = addr_q;
    assign m_avl_wrdata = wrdata_q;

    // Next-state and strobe decode; bus strobes depend on registered state only.
    always_comb begin
        state_n     = state;
        cmd_ready   = 1'b0;
        m_avl_wrena = 1'b0;
        m_avl_rdena = 1'b0;
        rsp_valid   = 1'b0;
        cmd_take    = 1'b0;
        bus_accept  = 1'b0;
        time_out    = 1'b0;
        rd_capture  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ~avl_rst;
                if (cmd_valid && cmd_ready) begin
                    cmd_take = 1'b1;
                    state_n  = ACCESS;
                end
            end
            ACCESS: begin
                m_avl_wrena = write_q;
                m_avl_rdena = ~write_q;
                if (!m_avl_wrq) begin
                    // Acceptance takes priority over a timeout in the same cycle.
                    bus_accept = 1'b1;
                    if (write_q) begin
                        state_n = RESP;
                    end else if (pRD_LATENCY == 0) begin
                        rd_capture = 1'b1;
                        state_n    = RESP;
                    end else begin
                        state_n = RDWAIT;
                    end
                end else if ((pTIMEOUT > 0) && (wait_cnt == WAIT_LAST)) begin
                    time_out = 1'b1;
                    state_n  = RESP;
                end
            end
            RDWAIT: begin
                if (lat_cnt == 4'd0) begin
                    rd_capture = 1'b1;
                    state_n    = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge avl_clock) begin
        if (avl_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Command capture, wait/latency counters and response fields.
    always_ff @(posedge avl_clock) begin
        if (avl_rst) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            wrdata_q    <= '0;
            wait_cnt    <= '0;
            lat_cnt     <= 4'd0;
            rsp_write   <= 1'b0;
            rsp_rddata  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (cmd_take) begin
                write_q  <= cmd_write;
                addr_q   <= cmd_addr;
                wrdata_q <= cmd_wrdata;
                wait_cnt <= '0;
            end else if ((state == ACCESS) && m_avl_wrq && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end

            if (bus_accept && !write_q) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == RDWAIT) && (lat_cnt != 4'd0)) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (rd_capture) begin
                rsp_write   <= 1'b0;
                rsp_rddata  <= m_avl_rddata;
                rsp_timeout <= 1'b0;
            end else if (time_out) begin
                rsp_write   <= write_q;
                rsp_rddata  <= '0;
                rsp_timeout <= 1'b1;
            end else if (bus_accept && write_q) begin
                rsp_write   <= 1'b1;
                rsp_rddata  <= '0;
                rsp_timeout <= 1'b0;
            end
        end
    end

    // Interrupt rising-edge detector, independent of the command FSM.
    always_ff @(posedge avl_clock) begin
        if (avl_rst) begin
            irq_q     <= 1'b0;
            irq_pulse <= 1'b0;
        end else begin
            irq_q     <= m_avl_irq;
            irq_pulse <= m_avl_irq & ~irq_q;
        end
    end

endmodule

// File: doc/avl_cmd_master.md
Name: avl_cmd_master

Overview:
- Initiator for the simple avl register bus: drives the exported m_avl_* signal set toward an avl slave.
- Accepts single read/write commands on a valid/ready command port and executes each as one avl transfer, honouring wait request (m_avl_wrq) and a fixed read latency.
- Returns one response per command on a response port, with a timeout flag.
- Converts the slave interrupt level into a one-cycle pulse.

Parameters:
- pADDR_WIDTH, 8, avl address width.
- pDATA_WIDTH, 32, avl data width.
- pRD_LATENCY, 1, cycles from read acceptance to valid m_avl_rddata; legal range 0..15.
- pTIMEOUT, 255, maximum cycles a strobe is held under wait request; 0 disables the timeout.

Ports:
- avl_clock  in  1  clock for all logic.
- avl_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  pADDR_WIDTH  target address.
- cmd_wrdata  in  pDATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_write  out  1  echo of the command type.
- rsp_rddata  out  pDATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  the transfer was aborted by timeout.
- irq_pulse  out  1  one-cycle pulse on a rising edge of m_avl_irq.
- m_avl_addr  out  pADDR_WIDTH  bus address.
- m_avl_wrena  out  1  write strobe.
- m_avl_wrdata  out  pDATA_WIDTH  write data.
- m_avl_rdena  out  1  read strobe.
- m_avl_rddata  in  pDATA_WIDTH  read data from the slave.
- m_avl_irq  in  1  slave interrupt level.
- m_avl_wrq  in  1  wait request; a strobe is accepted in a cycle where this is 0.

Behaviour:
- Clocking and reset: one clock, avl_clock. avl_rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0. cmd_ready is forced to 0 while avl_rst is high.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register addr, wrdata and write, clear wait_cnt, and go to ACCESS.
  - Commands are never accepted in any other state.
- ACCESS:
  - m_avl_wrena = write_q, m_avl_rdena = ~write_q.
  - Strobes are decoded from registered state only; there is no combinational path from m_avl_wrq to any output.
  - m_avl_addr and m_avl_wrdata come from registers and hold their value outside ACCESS.
  - Acceptance: m_avl_wrq = 0 sampled while in ACCESS; the strobe drops the next cycle.
    - Write: go to RESP.
    - Read with pRD_LATENCY = 0: capture m_avl_rddata in the acceptance cycle, then go to RESP.
    - Read with pRD_LATENCY > 0: go to RDWAIT and load lat_cnt.
  - m_avl_wrq = 1: wait_cnt increments.
  - Timeout: if pTIMEOUT > 0 and the strobe has been high pTIMEOUT cycles with wrq high in every one, go to RESP with rsp_timeout = 1 and rsp_rddata = 0.
  - Simultaneous events: acceptance in the pTIMEOUT-th cycle wins over timeout.
- RDWAIT: with acceptance in cycle t, capture m_avl_rddata at the end of cycle t + pRD_LATENCY, then go to RESP. No strobe is asserted in this state.
- RESP: rsp_valid = 1 for exactly one cycle (no backpressure), then go to IDLE. rsp_* fields hold their value until the next response.
- Latency, measured from acceptance cycle t:
  - Write: rsp_valid in cycle t + 1.
  - Read: rsp_valid in cycle t + pRD_LATENCY + 1.
  - Minimum command-to-command spacing with no wait states is 3 cycles (IDLE, ACCESS, RESP) plus pRD_LATENCY for reads.
- Counters: wait_cnt is $clog2(pTIMEOUT+1) bits and saturates; it never wraps. lat_cnt is 4 bits.
- irq: irq_q <= m_avl_irq each cycle. irq_pulse is registered, = m_avl_irq & ~irq_q, so it is high one cycle after the rising edge is sampled. A held-high irq produces exactly one pulse. irq logic runs independently of the FSM; irq_q resets to 0, so irq already high at reset release gives one pulse.
- Reset mid-transfer: strobes are 0 in the cycle after avl_rst is sampled high, no response is issued, and the in-flight command is dropped.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, wrq = 0 -> m_avl_wrena high exactly 1 cycle with addr 0x10 and data 0xDEADBEEF; rsp_valid the next cycle with rsp_write = 1 and rsp_timeout = 0.
- Read addr 0x04, pRD_LATENCY = 1, slave returns 0x12345678 one cycle after acceptance -> rdena high 1 cycle; rsp_valid 2 cycles after acceptance with rsp_rddata = 0x12345678.
- Write with wrq high for 3 cycles then low -> wrena high 4 cycles, addr and data stable throughout; single response with no timeout.
- pTIMEOUT = 4 with wrq stuck high -> strobe high exactly 4 cycles; rsp_timeout = 1, rsp_rddata = 0. Repeat with wrq going low in cycle 4 -> accepted, rsp_timeout = 0.
- Back-to-back commands with cmd_valid held high -> cmd_ready high only in IDLE; second write strobe starts 3 cycles after the first; no command is lost or duplicated.
- m_avl_irq 0 -> 1 held 10 cycles -> exactly one irq_pulse. avl_rst asserted during ACCESS under wrq -> strobe 0 the next cycle, no rsp_valid, cmd_ready = 0 while reset is high.
